// File: rtl/demux1to3_stream_if.sv
// Handshake bundle between one producer, the 1-to-3 demux and its three consumers.
// Directions are named from the demux's point of view (i_ = into the demux).
interface demux1to3_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_valid;
  logic                  o_ready;
  logic [1:0]            i_dest;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_valid_0;
  logic                  o_valid_1;
  logic                  o_valid_2;
  logic                  i_ready_0;
  logic                  i_ready_1;
  logic                  i_ready_2;
  logic [DATA_WIDTH-1:0] o_data_0;
  logic [DATA_WIDTH-1:0] o_data_1;
  logic [DATA_WIDTH-1:0] o_data_2;
  logic [CNT_WIDTH-1:0]  o_drop_count;

  modport slave (
    input  i_valid, i_dest, i_data, i_ready_0, i_ready_1, i_ready_2,
    output o_ready, o_valid_0, o_valid_1, o_valid_2,
    output o_data_0, o_data_1, o_data_2, o_drop_count
  );

  modport master (
    output i_valid, i_dest, i_data, i_ready_0, i_ready_1, i_ready_2,
    input  o_ready, o_valid_0, o_valid_1, o_valid_2,
    input  o_data_0, o_data_1, o_data_2, o_drop_count
  );
endinterface

// File: rtl/demux1to3_stream.sv
// Buffered 1-to-3 stream demultiplexer: three single-entry output registers, dest 3
// discards the payload and bumps a saturating drop counter.
module demux1to3_stream #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  demux1to3_stream_if.slave    bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            valid_r;
  logic [DATA_WIDTH-1:0] data_r [3];
  logic [CNT_WIDTH-1:0]  drop_count_r;
  logic [2:0]            cons_ready_s;
  logic [2:0]            load_s;
  logic                  ready_s;
  logic                  drop_s;

  assign cons_ready_s = {bus.i_ready_2, bus.i_ready_1, bus.i_ready_0};

  // A lane accepts when it is empty or is being drained in the same cycle (replace-on-drain).
  always_comb begin
    ready_s = 1'b1;
    load_s  = 3'b000;
    drop_s  = 1'b0;
    case (bus.i_dest)
      2'd0:    ready_s = ~valid_r[0] | cons_ready_s[0];
      2'd1:    ready_s = ~valid_r[1] | cons_ready_s[1];
      2'd2:    ready_s = ~valid_r[2] | cons_ready_s[2];
      2'd3:    ready_s = 1'b1;
      default: ready_s = 1'b1;
    endcase
    if (bus.i_valid && ready_s) begin
      case (bus.i_dest)
        2'd0:    load_s = 3'b001;
        2'd1:    load_s = 3'b010;
        2'd2:    load_s = 3'b100;
        2'd3:    drop_s = 1'b1;
        default: drop_s = 1'b0;
      endcase
    end else begin
      load_s = 3'b000;
      drop_s = 1'b0;
    end
  end

  // Lane registers and drop counter; lane data is only written on load and never cleared by a drain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r      <= 3'b000;
      drop_count_r <= {CNT_WIDTH{1'b0}};
      for (int k = 0; k < 3; k++) begin
        data_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (load_s[k]) begin
          valid_r[k] <= 1'b1;
          data_r[k]  <= bus.i_data;
        end else if (valid_r[k] && cons_ready_s[k]) begin
          valid_r[k] <= 1'b0;
        end else begin
          valid_r[k] <= valid_r[k];
        end
      end
      if (drop_s && (drop_count_r != CNT_MAX)) begin
        drop_count_r <= drop_count_r + CNT_ONE;
      end else begin
        drop_count_r <= drop_count_r;
      end
    end
  end

  assign bus.o_ready      = ready_s;
  assign bus.o_valid_0    = valid_r[0];
  assign bus.o_valid_1    = valid_r[1];
  assign bus.o_valid_2    = valid_r[2];
  assign bus.o_data_0     = data_r[0];
  assign bus.o_data_1     = data_r[1];
  assign bus.o_data_2     = data_r[2];
  assign bus.o_drop_count = drop_count_r;
endmodule

// File: tb/tb_demux1to3_stream.sv
// Self-checking bench for demux1to3_stream: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_demux1to3_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  demux1to3_stream_if #(.DATA_WIDTH(64), .CNT_WIDTH(16)) bus ();
  demux1to3_stream_if #(.DATA_WIDTH(8),  .CNT_WIDTH(2))  nbus ();

  demux1to3_stream #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  demux1to3_stream #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_narrow (
    .i_clk(clk), .i_rst(rst), .bus(nbus)
  );

  typedef struct {
    logic        v;
    logic [1:0]  dest;
    logic [63:0] data;
    logic [2:0]  rdy;
    logic        exp_ready;
    logic [2:0]  exp_valid;
    logic [15:0] exp_cnt;
    int          lane;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[21];

  // reference model state
  logic [63:0] lane_q [3][$];
  logic [63:0] last_data [3];
  int          model_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] valids();
    return {bus.o_valid_2, bus.o_valid_1, bus.o_valid_0};
  endfunction

  function automatic logic [63:0] lane_data(input int k);
    case (k)
      0:       return bus.o_data_0;
      1:       return bus.o_data_1;
      default: return bus.o_data_2;
    endcase
  endfunction

  function automatic vec_t mk(input logic v, input logic [1:0] d, input logic [63:0] dat,
                              input logic [2:0] r, input logic er, input logic [2:0] ev,
                              input logic [15:0] ec, input int ln, input logic [63:0] ed);
    vec_t t;
    t.v = v; t.dest = d; t.data = dat; t.rdy = r; t.exp_ready = er;
    t.exp_valid = ev; t.exp_cnt = ec; t.lane = ln; t.exp_data = ed;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [1:0] d, input logic [63:0] dat, input logic [2:0] r);
    bus.i_valid = v; bus.i_dest = d; bus.i_data = dat;
    {bus.i_ready_2, bus.i_ready_1, bus.i_ready_0} = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        hold;
    logic        r_v;
    logic [1:0]  r_d;
    logic [63:0] r_data;
    logic [2:0]  r_rdy;
    logic        exp_rdy;

    drive(1'b0, 2'd0, 64'd0, 3'b000);
    nbus.i_valid = 1'b0; nbus.i_dest = 2'd0; nbus.i_data = 8'd0;
    nbus.i_ready_0 = 1'b0; nbus.i_ready_1 = 1'b0; nbus.i_ready_2 = 1'b0;

    //             v     dest  data    rdy     rdy?  valid   cnt  lane data
    tbl[0]  = mk(1'b1, 2'd1, 64'hA5, 3'b000, 1'b1, 3'b010, 16'd0, 1, 64'hA5);
    tbl[1]  = mk(1'b1, 2'd0, 64'h11, 3'b000, 1'b1, 3'b011, 16'd0, 0, 64'h11);
    tbl[2]  = mk(1'b1, 2'd0, 64'h22, 3'b000, 1'b0, 3'b011, 16'd0, 0, 64'h11);
    tbl[3]  = mk(1'b1, 2'd0, 64'h22, 3'b000, 1'b0, 3'b011, 16'd0, 0, 64'h11);
    tbl[4]  = mk(1'b1, 2'd0, 64'h22, 3'b000, 1'b0, 3'b011, 16'd0, 0, 64'h11);
    tbl[5]  = mk(1'b1, 2'd0, 64'h22, 3'b000, 1'b0, 3'b011, 16'd0, 0, 64'h11);
    tbl[6]  = mk(1'b1, 2'd0, 64'h22, 3'b000, 1'b0, 3'b011, 16'd0, 0, 64'h11);
    tbl[7]  = mk(1'b1, 2'd0, 64'h22, 3'b001, 1'b1, 3'b011, 16'd0, 0, 64'h22);
    tbl[8]  = mk(1'b0, 2'd0, 64'h00, 3'b011, 1'b1, 3'b000, 16'd0, 0, 64'h22);
    tbl[9]  = mk(1'b1, 2'd3, 64'h77, 3'b000, 1'b1, 3'b000, 16'd1, 1, 64'hA5);
    tbl[10] = mk(1'b1, 2'd3, 64'h78, 3'b000, 1'b1, 3'b000, 16'd2, 1, 64'hA5);
    tbl[11] = mk(1'b1, 2'd3, 64'h79, 3'b000, 1'b1, 3'b000, 16'd3, 0, 64'h22);
    tbl[12] = mk(1'b1, 2'd1, 64'h33, 3'b000, 1'b1, 3'b010, 16'd3, 1, 64'h33);
    tbl[13] = mk(1'b1, 2'd0, 64'h44, 3'b000, 1'b1, 3'b011, 16'd3, 0, 64'h44);
    tbl[14] = mk(1'b1, 2'd1, 64'h55, 3'b001, 1'b0, 3'b010, 16'd3, 1, 64'h33);
    tbl[15] = mk(1'b1, 2'd1, 64'h55, 3'b010, 1'b1, 3'b010, 16'd3, 1, 64'h55);
    tbl[16] = mk(1'b1, 2'd2, 64'h01, 3'b100, 1'b1, 3'b110, 16'd3, 2, 64'h01);
    tbl[17] = mk(1'b1, 2'd2, 64'h02, 3'b100, 1'b1, 3'b110, 16'd3, 2, 64'h02);
    tbl[18] = mk(1'b1, 2'd2, 64'h03, 3'b100, 1'b1, 3'b110, 16'd3, 2, 64'h03);
    tbl[19] = mk(1'b1, 2'd2, 64'h04, 3'b100, 1'b1, 3'b110, 16'd3, 2, 64'h04);
    tbl[20] = mk(1'b0, 2'd3, 64'h00, 3'b110, 1'b1, 3'b000, 16'd3, 2, 64'h04);

    // reset for two cycles
    rst = 1'b1;
    step(); step();
    chk("reset_valid", {61'd0, valids()}, 64'd0);
    chk("reset_data0", bus.o_data_0, 64'd0);
    chk("reset_data1", bus.o_data_1, 64'd0);
    chk("reset_data2", bus.o_data_2, 64'd0);
    chk("reset_cnt", {48'd0, bus.o_drop_count}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].dest, tbl[i].data, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d_ready", i), {63'd0, bus.o_ready}, {63'd0, tbl[i].exp_ready});
      step();
      chk($sformatf("vec%0d_valid", i), {61'd0, valids()}, {61'd0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_cnt", i), {48'd0, bus.o_drop_count}, {48'd0, tbl[i].exp_cnt});
      chk($sformatf("vec%0d_data", i), lane_data(tbl[i].lane), tbl[i].exp_data);
    end

    // reset with all lanes full and a payload on offer
    drive(1'b1, 2'd0, 64'hA0, 3'b000); step();
    drive(1'b1, 2'd1, 64'hB0, 3'b000); step();
    drive(1'b1, 2'd2, 64'hC0, 3'b000); step();
    chk("full_before_rst", {61'd0, valids()}, 64'h7);
    drive(1'b1, 2'd1, 64'hD0, 3'b000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 2'd0, 64'd0, 3'b000);
    chk("midrst_valid", {61'd0, valids()}, 64'd0);
    chk("midrst_cnt", {48'd0, bus.o_drop_count}, 64'd0);
    chk("midrst_data1", bus.o_data_1, 64'd0);

    // drop-counter saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      nbus.i_valid = 1'b1; nbus.i_dest = 2'd3; nbus.i_data = 8'(i);
      #1;
      chk($sformatf("sat%0d_ready", i), {63'd0, nbus.o_ready}, 64'd1);
      step();
      chk($sformatf("sat%0d_cnt", i), {62'd0, nbus.o_drop_count}, (i >= 2) ? 64'd3 : 64'(i + 1));
      chk($sformatf("sat%0d_valid", i),
          {61'd0, nbus.o_valid_2, nbus.o_valid_1, nbus.o_valid_0}, 64'd0);
    end
    nbus.i_valid = 1'b0;

    // random traffic against the queue model; model starts from the post-reset state
    for (int k = 0; k < 3; k++) begin
      lane_q[k].delete();
      last_data[k] = 64'd0;
    end
    model_cnt = 0;
    hold = 1'b0;
    r_v = 1'b0; r_d = 2'd0; r_data = 64'd0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!hold) begin
        r_v    = ($urandom_range(0, 3) != 0);
        r_d    = 2'($urandom_range(0, 3));
        r_data = {$urandom, $urandom};
      end
      r_rdy = 3'($urandom_range(0, 7));
      rst   = ($urandom_range(0, 199) == 0);
      drive(r_v, r_d, r_data, r_rdy);
      #1;
      exp_rdy = (r_d == 2'd3) || (lane_q[r_d].size() == 0) || r_rdy[r_d];
      chk("rand_ready", {63'd0, bus.o_ready}, {63'd0, exp_rdy});
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          lane_q[k].delete();
          last_data[k] = 64'd0;
        end
        model_cnt = 0;
        hold = 1'b0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (lane_q[k].size() != 0 && r_rdy[k]) void'(lane_q[k].pop_front());
        end
        if (r_v && exp_rdy) begin
          if (r_d == 2'd3) model_cnt = (model_cnt < 65535) ? model_cnt + 1 : 65535;
          else begin
            lane_q[r_d].push_back(r_data);
            last_data[r_d] = r_data;
          end
        end
        hold = r_v && !exp_rdy;
      end
      step();
      rst = 1'b0;
      chk("rand_valid", {61'd0, valids()},
          {61'd0, lane_q[2].size() != 0, lane_q[1].size() != 0, lane_q[0].size() != 0});
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rand_data%0d", k), lane_data(k), last_data[k]);
      end
      chk("rand_cnt", {48'd0, bus.o_drop_count}, 64'(model_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/demux1to3_stream.md
# demux1to3_stream

Buffered 1-to-3 stream demultiplexer with valid/ready handshakes, the steering counterpart of the 3-to-1 select muxes in the core datapath. It accepts one payload per cycle from a single producer and routes it, by a 2-bit destination code, into one of three single-entry output registers, each drained independently by its consumer. Destination code 3 discards the payload and counts the discard. It sits between a shared result source and three downstream consumers, for example the writeback, trace and debug paths.

## Interface
- DATA_WIDTH, 64, payload width in bits.
- CNT_WIDTH, 16, width of the saturating drop counter.

- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  producer has a payload.
- o_ready  output  1  block accepts the payload this cycle.
- i_dest  input  2  destination: 0, 1 or 2 selects a lane; 3 means drop.
- i_data  input  DATA_WIDTH  payload.
- o_valid_0 / o_valid_1 / o_valid_2  output  1  lane k holds a payload.
- i_ready_0 / i_ready_1 / i_ready_2  input  1  consumer k takes the payload this cycle.
- o_data_0 / o_data_1 / o_data_2  output  DATA_WIDTH  lane k payload.
- o_drop_count  output  CNT_WIDTH  number of accepted payloads with i_dest=3.

## Operation
- **Lane state.** Each lane k has two states:
  - EMPTY: o_valid_k=0.
  - FULL: o_valid_k=1.
- **Lane transitions.** Define drain_k = o_valid_k & i_ready_k, and load_k = i_valid & o_ready & (i_dest==k).
  - EMPTY -> FULL on load_k.
  - FULL -> EMPTY on drain_k & ~load_k.
  - FULL stays FULL on drain_k & load_k: the new payload replaces the old one in the same edge.
  - FULL holds otherwise.
- **Ready.** o_ready = (i_dest==3) | ~o_valid_d | i_ready_d, where d = i_dest.
  - o_ready is combinational on i_dest, o_valid_d and i_ready_d.
  - o_ready does not depend on i_valid.
- **Data capture.** o_data_k loads i_data only on load_k and holds otherwise, including while EMPTY.
  - Lane data holds its last value after a drain; it is not cleared.
- **Drop.** A drop occurs when i_valid & o_ready & i_dest==3.
  - No lane changes state.
  - o_drop_count increments by 1 and saturates at 2^CNT_WIDTH-1; it never wraps.
- **Head-of-line blocking.** A blocked payload (FULL lane, consumer not ready) stalls the producer. Other lanes continue to drain.
- **Lane independence.** There is no ordering guarantee between lanes. Within a lane, order is preserved.
- **Producer rules.** The producer must hold i_valid, i_dest and i_data stable while i_valid & ~o_ready. The block does not check this.
- **Consumer rules.** o_valid_k and o_data_k stay stable while o_valid_k & ~i_ready_k.

## Timing
- **Reset.** While i_rst=1 at a rising edge:
  - all lanes go EMPTY;
  - o_valid_0/1/2=0, o_data_0/1/2=0, o_drop_count=0;
  - load_k and drop are suppressed for that edge.
- **Reset mid-transfer.** A payload held FULL in any lane is lost. The consumer sees o_valid_k fall in the cycle after the reset edge.
- **Latency.** 1 cycle: a payload accepted at edge N is visible on o_valid_k/o_data_k from edge N to N+1.
- **Throughput.** 1 payload per cycle per lane when i_ready_k stays high, because replace-on-drain allows back-to-back loads.
- **Counter timing.** o_drop_count updates at the edge of the accepted drop and is visible the following cycle.
- **Ready paths.** There is no combinational path from i_data to any output. The paths from i_dest and i_ready_k to o_ready are combinational.

## Test plan
- **Reset values.** Apply reset for 2 cycles -> all o_valid_k=0, all o_data_k=0, o_drop_count=0. Then with i_valid=1, i_dest=1, i_data=0xA5 -> o_ready=1, and after 1 edge o_valid_1=1, o_data_1=0xA5.
- **Backpressure.** Lane 0 FULL with 0x11 and i_ready_0=0; present i_dest=0, i_data=0x22:
  - required: o_ready=0 and o_data_0 stays 0x11 for 5 cycles;
  - then raise i_ready_0: o_ready=1 the same cycle, and at the next edge o_data_0=0x22, o_valid_0=1.
- **Streaming.** With i_ready_2=1, send 4 payloads to lane 2 on consecutive cycles (1, 2, 3, 4) -> o_ready stays 1 and o_data_2 shows 1, 2, 3, 4 on consecutive cycles.
- **Drop counting.** Send 3 payloads with i_dest=3 -> o_ready=1 each cycle, o_drop_count=3, and no o_valid_k rises. With CNT_WIDTH=2, 5 drops -> o_drop_count=3 (saturated).
- **Mixed lanes.** Lane 1 blocked FULL, lane 0 FULL with i_ready_0=1, producer targeting lane 1 -> lane 0 drains to EMPTY while the producer stalls.
- **Reset mid-operation.** Assert i_rst with all three lanes FULL and i_valid=1 -> next cycle all o_valid_k=0 and o_drop_count=0. The presented payload is not loaded.
